// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time pattern reload, valid qualification
// and a registered one-cycle detect pulse. Define SEQDET_CNT_EN to build the saturating match counter.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             det,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pat_q
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  nhist;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] nfill;
    logic              accept;
    logic              hit;

    // fill counts fresh bits so a window still holding stale or reset contents can never match
    always_comb begin
        accept = in_valid && !pat_load;
        nhist  = {hist[PAT_W-2:0], x};
        nfill  = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        hit    = accept && (nfill == FILL_FULL) && (nhist == pat_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist  <= '0;
            fill  <= '0;
            pat_q <= PATTERN;
            det   <= 1'b0;
        end else begin
            det <= hit;
            if (pat_load) begin
                pat_q <= pat_in;
                fill  <= '0;
            end else if (in_valid) begin
                hist <= nhist;
                fill <= (hit && !OVERLAP) ? '0 : nfill;
            end
        end
    end

`ifdef SEQDET_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (hit) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign match_cnt = cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised and directed bench for seq_detect_param: three instances (overlap, non-overlap,
// 2-bit counter) share one stimulus stream and are checked every cycle against a behavioural model.
module tb_seq_detect_param;

`ifdef SEQDET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       x;
    logic       in_valid;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       cnt_clr;

    logic       det0, det1, det2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [3:0] pq0, pq1, pq2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .det(det0), .match_cnt(cnt0), .pat_q(pq0));

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .det(det1), .match_cnt(cnt1), .pat_q(pq1));

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .det(det2), .match_cnt(cnt2), .pat_q(pq2));

    // Behavioural model: accepted-bit window plus, per instance, bits accepted since the last restart
    bit         ov[3]    = '{1'b1, 1'b0, 1'b1};
    int         cmax[3]  = '{255, 255, 3};
    bit         acc[$];
    int         since[3] = '{0, 0, 0};
    bit         edet[3]  = '{0, 0, 0};
    int         mcnt[3]  = '{0, 0, 0};
    bit         mh[3];
    logic [3:0] mpat     = 4'b1011;
    logic [3:0] mwin;

    always @(negedge rst) begin
        mpat = 4'b1011;
        acc.delete();
        for (int k = 0; k < 3; k++) begin
            since[k] = 0;
            edet[k]  = 1'b0;
            mcnt[k]  = 0;
        end
    end

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            for (int k = 0; k < 3; k++) mh[k] = 1'b0;
            if (pat_load) begin
                mpat = pat_in;
                for (int k = 0; k < 3; k++) since[k] = 0;
            end else if (in_valid) begin
                acc.push_back(x);
                if (acc.size() > 4) void'(acc.pop_front());
                mwin = '0;
                foreach (acc[i]) mwin = {mwin[2:0], acc[i]};
                for (int k = 0; k < 3; k++) begin
                    since[k]++;
                    mh[k] = (since[k] >= 4) && (mwin == mpat);
                    if (mh[k] && !ov[k]) since[k] = 0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                edet[k] = mh[k];
                if (cnt_clr) mcnt[k] = 0;
                else if (mh[k] && mcnt[k] < cmax[k]) mcnt[k]++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ecnt(input int k);
        return CNT_EN ? 32'(mcnt[k]) : 32'd0;
    endfunction

    always @(posedge clk) begin
        #1;
        chk("det_ov",  32'(det0), 32'(edet[0]));
        chk("det_no",  32'(det1), 32'(edet[1]));
        chk("det_sat", 32'(det2), 32'(edet[2]));
        chk("cnt_ov",  32'(cnt0), ecnt(0));
        chk("cnt_no",  32'(cnt1), ecnt(1));
        chk("cnt_sat", 32'(cnt2), ecnt(2));
        chk("pat_ov",  32'(pq0),  32'(mpat));
        chk("pat_no",  32'(pq1),  32'(mpat));
        chk("pat_sat", 32'(pq2),  32'(mpat));
    end

    task automatic drive(input logic v, input logic b, input logic ld, input logic [3:0] pi,
                         input logic clr);
        @(negedge clk);
        in_valid = v;
        x        = b;
        pat_load = ld;
        pat_in   = pi;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        drive(1'b1, b, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [6:0] stream = 7'b1011011;
    logic [3:0] rp;

    initial begin
        rst = 1'b0; x = 1'b0; in_valid = 1'b0; pat_load = 1'b0; pat_in = 4'h0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_det",   32'(det0), 32'd0);
        chk("rst_cnt",   32'(cnt0), 32'd0);
        chk("rst_pat",   32'(pq0),  32'hB);
        @(negedge clk);
        rst = 1'b1;

        // 1,0,1,1,0,1,1 continuous
        for (int i = 6; i >= 0; i--) begin
            send(stream[i]);
            if (i == 3) begin
                chk("ov_first",  32'(det0), 32'd1);
                chk("no_first",  32'(det1), 32'd1);
            end
        end
        chk("ov_second",  32'(det0), 32'd1);
        chk("no_second",  32'(det1), 32'd0);
        chk("ov_cnt2",    32'(cnt0), CNT_EN ? 32'd2 : 32'd0);
        chk("no_cnt1",    32'(cnt1), CNT_EN ? 32'd1 : 32'd0);
        idle(2);

        // valid gaps of 3 idle cycles between bits
        do_reset();
        for (int i = 6; i >= 3; i--) begin
            send(stream[i]);
            if (i != 3) begin
                idle(3);
                chk("gap_det", 32'(det0), 32'd0);
            end
        end
        chk("gap_hit", 32'(det0), 32'd1);
        idle(1);
        chk("gap_after", 32'(det0), 32'd0);

        // reload to 0000 with a dropped same-edge sample
        drive(1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
        chk("load_pat", 32'(pq0), 32'h0);
        for (int i = 0; i < 3; i++) begin
            send(1'b0);
            chk("fill_gate", 32'(det0), 32'd0);
        end
        send(1'b0);
        chk("zero_hit", 32'(det0), 32'd1);

        // mid-stream asynchronous reset
        drive(1'b0, 1'b0, 1'b1, 4'hB, 1'b0);
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("pre_rst_det", 32'(det0), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_det", 32'(det0), 32'd0);
        chk("async_cnt", 32'(cnt0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send(1'b1); send(1'b0); send(1'b1);
        #2 rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        send(1'b1);
        chk("partial_gone", 32'(det0), 32'd0);

        // saturation with pattern 1111 and clear on a hit edge
        drive(1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 8; i++) send(1'b1);
        chk("sat_cnt",  32'(cnt2), CNT_EN ? 32'd3 : 32'd0);
        chk("sat_no",   32'(cnt1), CNT_EN ? 32'd2 : 32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        chk("clr_det",  32'(det2), 32'd1);
        chk("clr_cnt",  32'(cnt2), 32'd0);
        idle(1);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(3))
                0: rp = 4'hF;
                1: rp = 4'h0;
                2: rp = 4'hA;
                default: rp = 4'($urandom);
            endcase
            drive(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom_range(39) == 0), rp,
                  1'($urandom_range(49) == 0));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector: the next generation of the fixed 1011 Moore detector. The pattern width, the reset-time pattern and the overlap mode are set by parameters. The pattern can be reloaded at run time, samples are qualified by a valid strobe, and a saturating match counter is included. It sits on a single-bit serial input stream and drives a registered, Moore-style one-cycle detect pulse to downstream control logic.

## Interface
Parameters:
- PAT_W, 4: pattern width in bits; legal range 2..32.
- PATTERN, 4'b1011: pattern loaded at reset; PAT_W bits, MSB is the oldest bit in time.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = window restarts after each match.
- CNT_W, 8: match counter width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset (asserted when 0).
- x, input, 1: serial data bit.
- in_valid, input, 1: x is sampled only on edges where in_valid=1.
- pat_load, input, 1: load pat_in as the new pattern.
- pat_in, input, PAT_W: new pattern value, MSB oldest.
- cnt_clr, input, 1: synchronous clear of match_cnt.
- det, output, 1: registered detect pulse.
- match_cnt, output, CNT_W: saturating count of matches.
- pat_q, output, PAT_W: currently active pattern.

## Operation
- State:
  - hist[PAT_W-1:0]: shift window, newest bit in the LSB.
  - fill: 0..PAT_W, saturating count of valid bits currently in the window.
  - pat_q: active pattern.
  - det register.
  - match_cnt register.
- Reset (rst=0, asynchronous):
  - hist=0, fill=0, det=0, match_cnt=0, pat_q=PATTERN.
  - Applies immediately and mid-stream; any partial match is discarded.
- Accepted sample (in_valid=1, pat_load=0):
  - nhist = {hist[PAT_W-2:0], x}.
  - nfill = min(fill+1, PAT_W).
  - hit = (nfill==PAT_W) && (nhist==pat_q).
  - On the edge: hist<=nhist; fill<=nfill, except that fill<=0 when hit && OVERLAP==0.
- fill gating: a pattern such as all-zeros cannot match a window still holding reset contents. A full PAT_W fresh bits are always required after reset, after a pattern load, or after a non-overlap match.
- det:
  - det<=hit on every edge.
  - det<=0 on edges with no accepted sample.
  - det is never high for two cycles unless two consecutive accepted samples both hit, which is possible only with OVERLAP=1 and a periodic pattern such as 1111.
- Pattern load (pat_load=1):
  - pat_q<=pat_in, fill<=0, det<=0.
  - hist is left unchanged but is masked by fill.
  - pat_load has priority: a sample presented on the same edge is dropped.
- Counter:
  - cnt_clr=1: match_cnt<=0. cnt_clr has priority over a same-edge hit.
  - Otherwise a hit increments match_cnt, saturating at all-ones with no wrap.
  - pat_load does not clear the counter.
- Idle: while in_valid=0 all state holds except det, which returns to 0.

## Timing
- Latency: det goes high in the cycle immediately after the rising edge that accepts the final pattern bit. It is a registered, Moore output: no combinational path from x to det.
- match_cnt updates on the same edge that sets det.
- Throughput: one bit per clock. in_valid may be high continuously.
- Minimum bits between matches:
  - OVERLAP=1: period of the pattern's self-overlap (1 for 1111; 3 for 1011).
  - OVERLAP=0: PAT_W.
- Reset release: the first sample can be accepted on the first rising edge with rst=1. Recovery from reset deassertion is handled by the system reset synchroniser, not in this block.
- Outputs stable (hold value) while in_valid=0; det low.

## Configuration
- SEQDET_CNT_EN defined:
  - match_cnt register, increment logic and cnt_clr handling are built as described above.
- SEQDET_CNT_EN undefined:
  - Counter logic is removed.
  - match_cnt is tied to 0.
  - cnt_clr is ignored.
  - det, hist, fill and pattern behaviour are identical in both builds.

## Test plan
- Reset/default, OVERLAP=1:
  - Stimulus: rst low for 2 cycles, release, then in_valid=1 with x = 1,0,1,1,0,1,1.
  - Required: det pulses one cycle after the 4th bit and one cycle after the 7th bit; match_cnt=2.
- Non-overlap (OVERLAP=0):
  - Stimulus: same stream.
  - Required: det pulses after the 4th bit only; match_cnt=1.
- Valid gaps:
  - Stimulus: x = 1,0,1,1 with in_valid low for 3 cycles between every bit.
  - Required: exactly one det pulse, in the cycle after the 4th accepted edge; det=0 during all gaps.
- Pattern reload and fill gating:
  - Stimulus: pat_load with pat_in=4'b0000, then x = 0,0,0.
  - Required: no det.
  - Stimulus: one further 0.
  - Required: det=1. A same-edge in_valid during pat_load is dropped, i.e. not counted toward fill.
- Mid-stream reset:
  - Stimulus: x = 1,0,1; rst low asynchronously between edges; release; x = 1.
  - Required: det, match_cnt and fill read 0 immediately on rst low; no det after the final 1.
- Counter saturation and clear (SEQDET_CNT_EN, CNT_W=2):
  - Stimulus: 5 matches with OVERLAP=1 and pattern 1111, x = 1 ×8.
  - Required: match_cnt sticks at 3.
  - Stimulus: cnt_clr asserted together with a hit.
  - Required: match_cnt=0. Without SEQDET_CNT_EN, match_cnt=0 throughout.
